// File: rtl/regfile_multiport.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.

module regfile_mp_rd_port #(
   parameter int REG_COUNT  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [REG_COUNT*DATA_WIDTH-1:0] regs,
   input  logic [REG_COUNT-1:0]            busy,
   input  logic [ADDR_WIDTH-1:0]           rd_addr,
   output logic [DATA_WIDTH-1:0]           rd_data,
   output logic                            rd_busy
);

   // Addresses beyond REG_COUNT match no entry and fall through to zero.
   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      for (int r = 0; r < REG_COUNT; r++) begin
         if (rd_addr == ADDR_WIDTH'(r)) begin
            rd_data = regs[r*DATA_WIDTH +: DATA_WIDTH];
            rd_busy = busy[r];
         end
      end
   end

endmodule

module regfile_multiport #(
   parameter int REG_COUNT  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic                         issue_en,
   input  logic [ADDR_WIDTH-1:0]        issue_addr,
   output logic [REG_COUNT-1:0]         busy_vec
);

   logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wa;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wd;
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    ra;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]    st_data;
   logic [NUM_RD-1:0]                    st_busy;
   logic [NUM_WR-1:0]                    wr_ok;
   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [REG_COUNT-1:0]                 busy_q, busy_d;

   assign wa = wr_addr;
   assign wd = wr_data;
   assign ra = rd_addr;

   // A write port is effective only for an in-range, non-hardwired target.
   always_comb begin
      wr_ok = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int r = 0; r < REG_COUNT; r++) begin
            if (wa[i] == ADDR_WIDTH'(r) && !(ZERO_REG != 0 && r == 0))
               wr_ok[i] = wr_en[i];
         end
      end
   end

   // Later ports override earlier ones; an issue overrides a completing write's clear.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int r = 0; r < REG_COUNT; r++) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i] && wa[i] == ADDR_WIDTH'(r)) begin
               regs_d[r] = wd[i];
               busy_d[r] = 1'b0;
            end
         end
         if (issue_en && issue_addr == ADDR_WIDTH'(r) && !(ZERO_REG != 0 && r == 0))
            busy_d[r] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      regfile_mp_rd_port #(
         .REG_COUNT  (REG_COUNT),
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_rd (
         .regs    (regs_q),
         .busy    (busy_q),
         .rd_addr (ra[j]),
         .rd_data (st_data[j]),
         .rd_busy (st_busy[j])
      );
   end

`ifdef REGFILE_MP_BYPASS_EN
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] byp_data;
   logic [NUM_RD-1:0]                 byp_busy;

   always_comb begin
      byp_data = st_data;
      byp_busy = st_busy;
      for (int j = 0; j < NUM_RD; j++) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i] && wa[i] == ra[j]) begin
               byp_data[j] = wd[i];
               byp_busy[j] = 1'b0;
            end
         end
      end
   end

   assign rd_data = byp_data;
   assign rd_busy = byp_busy;
`else
   assign rd_data = st_data;
   assign rd_busy = st_busy;
`endif

   assign busy_vec = busy_q;

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port integer register file with a per-register pending-write scoreboard, the next-generation replacement for the single-write, dual-read core register file. It serves wider issue configurations (N read ports, M write-back ports) and tracks which registers have an outstanding producer, so issue logic can stall on RAW hazards without a separate scoreboard block. It sits between decode/issue (reads, issue marking) and the write-back stage(s).

## Interface
- REG_COUNT, 32, number of architectural registers
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; must satisfy 2**ADDR_WIDTH >= REG_COUNT
- NUM_RD, 2, number of read ports (1..8)
- NUM_WR, 2, number of write ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero, 0 = register 0 is ordinary storage

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_WIDTH  write addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wr_data  in  NUM_WR*DATA_WIDTH  write data, packed likewise
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses, packed
- rd_data  out  NUM_RD*DATA_WIDTH  read data, packed
- rd_busy  out  NUM_RD  addressed register has a pending producer
- issue_en  in  1  mark issue_addr busy (new in-flight producer)
- issue_addr  in  ADDR_WIDTH  destination being issued
- busy_vec  out  REG_COUNT  raw scoreboard, bit r = register r pending

## Operation
- Storage: REG_COUNT x DATA_WIDTH flops; rst clears all to 0 and all busy bits to 0, asynchronously.
- Writes: on rising edge, each port i with wr_en[i]=1 and a valid address writes wr_data[i].
- Write conflict: several ports hitting the same address in one cycle -> highest port index wins.
- Invalid address (>= REG_COUNT): write ignored; read returns 0; rd_busy 0; issue ignored.
- Register 0 (ZERO_REG=1): writes ignored, reads 0, busy bit never set (issue to r0 is a no-op).
- Reads: combinational from storage; no read enable.
- Scoreboard: busy[r] set at edge when issue_en=1 and issue_addr=r; cleared at edge when any write port writes r.
- Same-cycle set and clear of the same r: set wins (new producer supersedes completing one); data is still written.
- Re-issue of an already-busy register: stays busy; no counting (in-order single outstanding producer per register).
- busy_vec is the registered scoreboard; rd_busy[j] = busy_vec[rd_addr[j]] subject to bypass rules below.

## Timing
- Reset values: rd_data = 0 on all ports, rd_busy = 0, busy_vec = 0, while rst is high and after release until first write/issue.
- rst asserted mid-cycle: storage and scoreboard clear immediately, no edge required; a write on the same edge as rst deassertion is NOT taken if rst is still high at that edge.
- Write latency: data visible on rd_data in the cycle after the write edge (without bypass); same cycle with bypass.
- Issue latency: busy bit visible on busy_vec/rd_busy the cycle after issue edge; issue is never bypassed.
- No handshake; all inputs sampled every edge.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en[i] and wr_addr[i]==rd_addr[j] (valid, non-zero when ZERO_REG=1), rd_data[j]=wr_data[i] combinationally (highest matching i wins) and rd_busy[j]=0 that cycle.
- Undefined: rd_data reflects storage only; rd_busy reflects registered busy only; same-cycle write is invisible until next cycle.

## Test plan
- Reset: write r1=0xDEADBEEF, r2=0xCAFEBABE, pulse rst between edges -> rd_data on all ports 0 immediately, busy_vec=0.
- Multi-port write: port0 r3=0x11111111, port1 r4=0x22222222 same edge -> next cycle read r3/r4 return those values; r0 write 0xFFFFFFFF -> reads 0.
- Conflict: port0 and port1 both write r5 (0xAAAA0000, 0x5555FFFF) -> r5 = 0x5555FFFF.
- Scoreboard: issue r6 -> busy_vec[6]=1 next cycle, rd_busy=1 reading r6; write r6 with simultaneous issue r6 -> stays busy; later write r6 alone -> busy clears next cycle.
- Bypass: write r7=0x12345678 while reading r7 same cycle -> with REGFILE_MP_BYPASS_EN rd_data=0x12345678, rd_busy=0; without it old value (0) until next cycle.
- Invalid address (REG_COUNT=24): write/issue r30 -> ignored; read r30 returns 0, rd_busy 0.
